// File: rtl/seq_gen_1011.sv
// seq_gen_1011: framed serial transmitter for the 1011 link.
// A word accepted over valid/ready goes out one bit per clock as the sync
// word 1011, then the data word MSB-first, then GAP idle zeros.
// All serial outputs are registered from the next-state values, so each bit
// appears on out_bit in the same cycle that the state machine sits on it.
module seq_gen_1011 #(
   parameter int WIDTH = 8,
   parameter int GAP   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             out_bit,
   output logic             busy,
   output logic             sync_done,
   output logic             frame_done
);

   localparam int              CW        = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   DATA_LAST = CW'(WIDTH - 1);
   localparam logic [3:0]      GAP_LAST  = 4'((GAP > 0) ? (GAP - 1) : 0);
   localparam logic [3:0]      SYNC_PAT  = 4'b1011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   state_t            state_r,      state_n_s;
   logic [1:0]        sync_idx_r,   sync_idx_n_s;
   logic [CW-1:0]     data_cnt_r,   data_cnt_n_s;
   logic [3:0]        gap_cnt_r,    gap_cnt_n_s;
   logic [WIDTH-1:0]  shreg_r,      shreg_n_s;
   logic              out_bit_r,    out_bit_n_s;
   logic              sync_done_r,  sync_done_n_s;
   logic              frame_done_r, frame_done_n_s;
   logic              data_ready_s;
   logic              handshake_s;

   // Ready only in IDLE and only while reset is released.
   assign data_ready_s = (state_r == ST_IDLE) && reset;
   assign handshake_s  = data_valid && data_ready_s;

   // Next-state, counter and shift-register logic.
   always_comb begin
      state_n_s    = state_r;
      sync_idx_n_s = sync_idx_r;
      data_cnt_n_s = data_cnt_r;
      gap_cnt_n_s  = gap_cnt_r;
      shreg_n_s    = shreg_r;
      case (state_r)
         ST_IDLE: begin
            if (handshake_s) begin
               state_n_s    = ST_SYNC;
               sync_idx_n_s = 2'd0;
               shreg_n_s    = data_in;
            end else begin
               state_n_s    = ST_IDLE;
            end
         end
         ST_SYNC: begin
            if (sync_idx_r == 2'd3) begin
               state_n_s    = ST_DATA;
               data_cnt_n_s = '0;
            end else begin
               sync_idx_n_s = sync_idx_r + 2'd1;
            end
         end
         ST_DATA: begin
            if (data_cnt_r == DATA_LAST) begin
               if (GAP > 0) begin
                  state_n_s   = ST_GAP;
                  gap_cnt_n_s = 4'd0;
               end else begin
                  state_n_s   = ST_IDLE;
               end
            end else begin
               data_cnt_n_s = data_cnt_r + CW'(1);
               shreg_n_s    = shreg_r << 1;
            end
         end
         ST_GAP: begin
            if (gap_cnt_r == GAP_LAST) begin
               state_n_s   = ST_IDLE;
            end else begin
               gap_cnt_n_s = gap_cnt_r + 4'd1;
            end
         end
         default: begin
            state_n_s = ST_IDLE;
         end
      endcase
   end

   // Serial bit and pulses for the cycle the machine is about to enter.
   always_comb begin
      out_bit_n_s    = 1'b0;
      sync_done_n_s  = 1'b0;
      frame_done_n_s = 1'b0;
      case (state_n_s)
         ST_SYNC: begin
            out_bit_n_s   = SYNC_PAT[2'd3 - sync_idx_n_s];
            sync_done_n_s = (sync_idx_n_s == 2'd3);
         end
         ST_DATA: begin
            out_bit_n_s    = shreg_n_s[WIDTH-1];
            frame_done_n_s = (data_cnt_n_s == DATA_LAST);
         end
         default: begin
            out_bit_n_s = 1'b0;
         end
      endcase
   end

   // State, counters and shift register; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         sync_idx_r <= 2'd0;
         data_cnt_r <= '0;
         gap_cnt_r  <= 4'd0;
         shreg_r    <= '0;
      end else begin
         state_r    <= state_n_s;
         sync_idx_r <= sync_idx_n_s;
         data_cnt_r <= data_cnt_n_s;
         gap_cnt_r  <= gap_cnt_n_s;
         shreg_r    <= shreg_n_s;
      end
   end

   // Registered serial output and status pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_bit_r    <= 1'b0;
         sync_done_r  <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         out_bit_r    <= out_bit_n_s;
         sync_done_r  <= sync_done_n_s;
         frame_done_r <= frame_done_n_s;
      end
   end

   assign data_ready = data_ready_s;
   assign out_bit    = out_bit_r;
   assign busy       = (state_r != ST_IDLE);
   assign sync_done  = sync_done_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seq_gen_1011.sv
// Bench for seq_gen_1011: WIDTH=8/GAP=2 instance checked against a
// per-cycle scoreboard, plus a WIDTH=1/GAP=0 instance checked against a
// fixed expected bit stream.
module tb_seq_gen_1011;

   typedef struct packed {
      logic ob;
      logic bz;
      logic sd;
      logic fd;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready, out_bit, busy, sync_done, frame_done;

   logic [0:0] data_in1;
   logic       data_valid1;
   logic       data_ready1, out_bit1, busy1, sync_done1, frame_done1;

   exp_t q[$];
   int   sync_cycles[$];
   int   errors = 0;
   int   checks = 0;
   int   cycle = 0;
   int   hs_count = 0;
   logic cur_idle = 1'b1;

   always #5 clk = ~clk;

   seq_gen_1011 #(.WIDTH(8), .GAP(2)) u_dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready), .out_bit(out_bit), .busy(busy),
      .sync_done(sync_done), .frame_done(frame_done)
   );

   seq_gen_1011 #(.WIDTH(1), .GAP(0)) u_dut1 (
      .clk(clk), .reset(reset), .data_in(data_in1), .data_valid(data_valid1),
      .data_ready(data_ready1), .out_bit(out_bit1), .busy(busy1),
      .sync_done(sync_done1), .frame_done(frame_done1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
      end
   endtask

   // Expected per-cycle outputs of one WIDTH=8/GAP=2 frame.
   task automatic push_frame(input logic [7:0] d);
      logic [3:0] pat;
      exp_t e;
      pat = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         e = '{ob: pat[3-i], bz: 1'b1, sd: (i == 3), fd: 1'b0};
         q.push_back(e);
      end
      for (int i = 0; i < 8; i++) begin
         e = '{ob: d[7-i], bz: 1'b1, sd: 1'b0, fd: (i == 7)};
         q.push_back(e);
      end
      for (int i = 0; i < 2; i++) begin
         e = '{ob: 1'b0, bz: 1'b1, sd: 1'b0, fd: 1'b0};
         q.push_back(e);
      end
   endtask

   // One clock: predict a handshake, advance, then compare at the falling edge.
   task automatic tick();
      exp_t e;
      if (data_valid && cur_idle && reset) begin
         push_frame(data_in);
         hs_count++;
      end
      @(posedge clk);
      @(negedge clk);
      cycle++;
      if (q.size() > 0) begin
         e = q.pop_front();
         cur_idle = 1'b0;
      end else begin
         e = '{ob: 1'b0, bz: 1'b0, sd: 1'b0, fd: 1'b0};
         cur_idle = 1'b1;
      end
      chk("out_bit",    32'(out_bit),    32'(e.ob));
      chk("busy",       32'(busy),       32'(e.bz));
      chk("sync_done",  32'(sync_done),  32'(e.sd));
      chk("frame_done", 32'(frame_done), 32'(e.fd));
      chk("data_ready", 32'(data_ready), 32'(cur_idle));
      if (sync_done) sync_cycles.push_back(cycle);
   endtask

   initial begin
      logic [11:0] w1_stream;
      int          start_hs;

      reset       = 1'b0;
      data_in     = 8'h00;
      data_valid  = 1'b0;
      data_in1    = 1'b0;
      data_valid1 = 1'b0;

      // Reset state.
      #12;
      chk("rst_out_bit",    32'(out_bit),    32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_sync_done",  32'(sync_done),  32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_data_ready", 32'(data_ready), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Idle for 50 cycles with no valid.
      for (int i = 0; i < 50; i++) tick();

      // Single frame 0xA5.
      data_in    = 8'hA5;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      data_in    = 8'h00;
      for (int i = 0; i < 15; i++) tick();

      // data_in toggles every cycle while busy; only the handshake value goes out.
      data_in    = 8'h3C;
      data_valid = 1'b1;
      tick();
      for (int i = 0; i < 15; i++) begin
         data_in = ~data_in;
         if (i == 5) data_valid = 1'b0;
         tick();
      end

      // Back-to-back 0xFF then 0x00 with valid held.
      sync_cycles.delete();
      start_hs   = hs_count;
      data_in    = 8'hFF;
      data_valid = 1'b1;
      tick();
      data_in = 8'h00;
      for (int i = 0; i < 40 && hs_count < start_hs + 2; i++) tick();
      chk("b2b_handshakes", 32'(hs_count - start_hs), 32'd2);
      data_valid = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      chk("b2b_sync_count", 32'(sync_cycles.size()), 32'd2);
      if (sync_cycles.size() >= 2)
         chk("b2b_sync_spacing", 32'(sync_cycles[1] - sync_cycles[0]), 32'd15);

      // Reset mid-frame during the data field of 0xC3.
      data_in    = 8'hC3;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      #2;
      reset = 1'b0;
      #1;
      chk("abort_out_bit",    32'(out_bit),    32'd0);
      chk("abort_busy",       32'(busy),       32'd0);
      chk("abort_sync_done",  32'(sync_done),  32'd0);
      chk("abort_frame_done", 32'(frame_done), 32'd0);
      chk("abort_data_ready", 32'(data_ready), 32'd0);
      q.delete();
      cur_idle = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_hold_busy", 32'(busy), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) tick();

      // WIDTH=1, GAP=0: words 1 then 0 back-to-back.
      w1_stream   = 12'b1011_10_1011_00;
      data_in1    = 1'b1;
      data_valid1 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("w1_out_bit[%0d]", i), 32'(out_bit1), 32'(w1_stream[11-i]));
         chk($sformatf("w1_frame_done[%0d]", i), 32'(frame_done1), 32'((i == 4) || (i == 10)));
         chk($sformatf("w1_sync_done[%0d]", i), 32'(sync_done1), 32'((i == 3) || (i == 9)));
         if (i == 0) data_in1 = 1'b0;
         if (i == 9) data_valid1 = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      chk("w1_final_ready", 32'(data_ready1), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_gen_1011.md
Name: seq_gen_1011

Overview:
Framed serial transmitter, the sending side of the 1011 serial link. Accepts a parallel data word over a valid/ready handshake and emits it one bit per clock: a 4-bit sync word 1011, then the data word MSB-first, then GAP idle zeros. Sits upstream of the 1011 sequence detector and drives its inp_bit.

Parameters:
WIDTH, 8, data word width in bits; legal range 1..32.
GAP, 2, idle zero bits driven after each frame before returning to IDLE; legal range 0..15.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
data_in  input  WIDTH  parallel word; sampled only on handshake
data_valid  input  1  upstream has a word on data_in
data_ready  output  1  block can accept a word this cycle
out_bit  output  1  serial output, registered
busy  output  1  high whenever state != IDLE
sync_done  output  1  one-cycle pulse, high in the cycle out_bit carries the 4th sync bit
frame_done  output  1  one-cycle pulse, high in the cycle out_bit carries the last data bit

Behaviour:
- Reset asserted (reset=0, asynchronous): state=IDLE, out_bit=0, busy=0, sync_done=0, frame_done=0, shift register and counters cleared, data_ready=0.
- Reset release: the first rising edge with reset=1 clocks normally. A reset asserted mid-frame aborts the frame immediately. No partial resume.
- data_ready = (state==IDLE) && reset. It is combinational from the state register.
- A handshake occurs on a rising edge with data_valid && data_ready.
- data_in is captured into a WIDTH-bit shift register only on a handshake. data_in changes at any other time are ignored.
- data_valid held high while busy has no effect.
- States:
  - IDLE: out_bit=0. On handshake, go to SYNC with sync index 0.
  - SYNC: out_bit = 1,0,1,1 on indices 0..3. After index 3, go to DATA.
  - DATA: out_bit = shift register MSB, WIDTH cycles, shifting left each cycle. After the last bit, go to GAP if GAP>0, else IDLE.
  - GAP: out_bit=0 for GAP cycles, then IDLE.
- Latency and timing: handshake edge at cycle T.
  - Sync bits at T+1..T+4; sync_done at T+4.
  - Data bits at T+5..T+4+WIDTH; frame_done at T+4+WIDTH.
  - GAP zeros follow. IDLE (out_bit=0, data_ready=1) is reached at T+5+WIDTH+GAP.
  - Minimum spacing between frames: GAP+1 zero bits (GAP state plus at least one IDLE cycle).
  - Back-to-back frames with data_valid held high: frame period = 5+WIDTH+GAP cycles.
- Counters: the sync index is 2 bits, the data counter is $clog2(WIDTH+1) bits, and the gap counter is 4 bits. Counters never wrap past their terminal count. Each is reloaded to 0 on entry to its state.
- Data is not escaped: a 1011 pattern inside data_in is transmitted as-is.
- sync_done and frame_done are never high in the same cycle. Each is high for exactly one cycle per frame.

Test Plan:
- WIDTH=8, GAP=2; handshake with data_in=0xA5 -> out_bit over 14 cycles = 1,0,1,1, 1,0,1,0,0,1,0,1, 0,0. sync_done on cycle 4, frame_done on cycle 12, busy high for 14 cycles. data_ready rises on cycle 15.
- Back-to-back: data_valid held high with 0xFF then 0x00 -> second sync starts exactly 15 cycles after the first. Zeros between frames = 3 (2 GAP + 1 IDLE). Second data field = eight 0s.
- data_in toggled every cycle while busy, data_valid held -> transmitted word equals the value present at the handshake edge only.
- Reset pulsed low during data bit 3 of 0xC3 -> out_bit, busy and pulses go 0 asynchronously without waiting for a clock. After release, IDLE with data_ready=1 and no residual bits emitted.
- data_valid=0 for 50 cycles after reset release -> out_bit constantly 0, busy=0, no pulses.
- Build WIDTH=1, GAP=0; words 1 then 0 back-to-back -> stream 1,0,1,1,1,0, 1,0,1,1,0,0. frame_done at cycles 5 and 11.
